// File: rtl/lcd4_pkg.sv
// -----------------------------------------------------------------------------
// lcd4_pkg
// Shared definitions for the HD44780 4-bit frame writer:
//   - LCD command bytes used by init and refresh
//   - top-level FSM state, per-byte sub-step and nibble transmitter phase enums
//   - small lookup helpers for the init nibble stream and config bytes
// -----------------------------------------------------------------------------
package lcd4_pkg;

    localparam logic [7:0] FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] ENTRY    = 8'h06;  // increment cursor, no shift
    localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LINE2    = 8'hC0;  // DDRAM address 0x40

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT_NIB,
        ST_CFG,
        ST_SNAP,
        ST_ADDR_A,
        ST_CHAR_A,
        ST_ADDR_B,
        ST_CHAR_B,
        ST_DONE
    } lcd_state_e;

    // Progress through one write: idle -> upper nibble -> gap -> lower nibble -> post wait.
    // Init nibbles enter directly at SB_LO.
    typedef enum logic [2:0] {
        SB_IDLE,
        SB_HI,
        SB_GAP,
        SB_LO,
        SB_WAIT
    } byte_step_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_HIGH
    } tx_phase_e;

    // Config byte sequence sent after the nibble-mode init.
    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FUNC_SET;
            2'd1:    b = ENTRY;
            2'd2:    b = DISP_ON;
            default: b = CLEAR;
        endcase
        return b;
    endfunction

    // Init nibble stream 3,3,3,2 (last one switches the controller to 4-bit mode).
    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == 2'd3) ? 4'h2 : 4'h3;
    endfunction

endpackage

// File: rtl/lcd4_nibble_tx.sv
// -----------------------------------------------------------------------------
// lcd4_nibble_tx
// Drives one nibble onto the LCD bus: RS/D are registered on start, E rises
// T_SETUP cycles later, stays high T_EHIGH cycles, then falls together with a
// one-cycle done pulse. RS/D stay valid until the next start.
// Starts seen while busy are ignored; the caller waits for done.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        launch a nibble (sampled only when idle)
//   rs_i, nib_i    register select and data nibble to send
//   e_o, rs_o, d_o LCD bus outputs
//   done_o         one-cycle pulse as E falls
// T_SETUP and T_EHIGH must both be at least 1.
// -----------------------------------------------------------------------------
module lcd4_nibble_tx
    import lcd4_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [3:0] nib_i,
    output logic       e_o,
    output logic       rs_o,
    output logic [3:0] d_o,
    output logic       done_o
);

    localparam int TMAX = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int CW   = $clog2(TMAX + 1);

    tx_phase_e       phase_q;
    logic [CW-1:0]   cnt_q;
    logic            e_q;
    logic            rs_q;
    logic [3:0]      d_q;
    logic            done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= TX_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                TX_IDLE: begin
                    if (start_i) begin
                        rs_q    <= rs_i;
                        d_q     <= nib_i;
                        cnt_q   <= CW'(T_SETUP - 1);
                        phase_q <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= CW'(T_EHIGH - 1);
                        phase_q <= TX_HIGH;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                TX_HIGH: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        done_q  <= 1'b1;
                        phase_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: phase_q <= TX_IDLE;
            endcase
        end
    end

    assign e_o    = e_q;
    assign rs_o   = rs_q;
    assign d_o    = d_q;
    assign done_o = done_q;

endmodule

// File: rtl/lcd4_frame_writer.sv
// -----------------------------------------------------------------------------
// lcd4_frame_writer
// HD44780 16x2 character LCD driver in 4-bit write-only mode. After reset it
// waits for power-up, runs the nibble init (3,3,3,2), sends the config bytes
// (28,06,0C,01), raises ready, then refreshes both text rows frame by frame.
// Each frame snapshots row_A/row_B so mid-frame input changes only show up in
// the next frame.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   row_A, row_B    16 ASCII bytes each, byte 0 = [127:120] = leftmost column
//   ready           high once init is complete, sticky until reset
//   refresh_done    one-cycle pulse after the last char of a frame
//   LCD_E/RS/RW/D   LCD bus (RW tied low)
// Optional feature macro: LCD_SKIP_UNCHANGED_EN -- when defined, a frame is
// only written if the inputs differ from the last written snapshot (the first
// frame after reset is always written).
// -----------------------------------------------------------------------------
module lcd4_frame_writer
    import lcd4_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12,
    parameter int T_GAP   = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row_A,
    input  logic [127:0] row_B,
    output logic         ready,
    output logic         refresh_done,
    output logic         LCD_E,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic [3:0]   LCD_D
);

    // One wait counter serves every step; T_PWRUP is the longest wait.
    localparam int WW = $clog2(T_PWRUP + 1);

    lcd_state_e     state_q;
    byte_step_e     sub_q;
    logic [WW-1:0]  wait_q;
    logic [WW-1:0]  post_q;     // wait after the lower nibble of the current write
    logic [1:0]     step_q;     // init nibble index, then config byte index
    logic [3:0]     idx_q;      // char column, wraps 15->0 at the row switch
    logic [3:0]     lo_q;       // lower nibble held across the T_GAP wait
    logic [3:0]     nib_q;
    logic           rs_q;
    logic           start_q;
    logic           ready_q;
    logic           done_q;
    logic [127:0]   shadow_a_q;
    logic [127:0]   shadow_b_q;
`ifdef LCD_SKIP_UNCHANGED_EN
    logic           written_q;  // at least one frame written since reset
`endif

    logic           tx_done;
    logic [7:0]     next_byte;
    logic           next_rs;
    logic [WW-1:0]  next_post;
    logic [WW-1:0]  init_wait;

    // Byte to send for the current state and its trailing wait.
    always_comb begin
        next_byte = 8'h00;
        next_rs   = 1'b0;
        next_post = WW'(T_CMD - 1);
        case (state_q)
            ST_CFG: begin
                next_byte = cfg_byte(step_q);
                if (step_q == 2'd3) next_post = WW'(T_CLEAR - 1);
            end
            ST_ADDR_A: next_byte = LINE1;
            ST_ADDR_B: next_byte = LINE2;
            ST_CHAR_A: begin
                next_byte = shadow_a_q[127 - 8*int'(idx_q) -: 8];
                next_rs   = 1'b1;
            end
            ST_CHAR_B: begin
                next_byte = shadow_b_q[127 - 8*int'(idx_q) -: 8];
                next_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (step_q)
            2'd0:    init_wait = WW'(T_INIT1 - 1);
            2'd1:    init_wait = WW'(T_INIT2 - 1);
            default: init_wait = WW'(T_CMD - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PWR_WAIT;
            sub_q      <= SB_IDLE;
            wait_q     <= WW'(T_PWRUP - 1);
            post_q     <= '0;
            step_q     <= 2'd0;
            idx_q      <= 4'd0;
            lo_q       <= 4'h0;
            nib_q      <= 4'h0;
            rs_q       <= 1'b0;
            start_q    <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
`ifdef LCD_SKIP_UNCHANGED_EN
            written_q  <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (sub_q)
                SB_IDLE: begin
                    case (state_q)
                        ST_PWR_WAIT: begin
                            if (wait_q == '0) begin
                                state_q <= ST_INIT_NIB;
                                step_q  <= 2'd0;
                            end else begin
                                wait_q <= wait_q - WW'(1);
                            end
                        end
                        ST_INIT_NIB: begin
                            // single nibble: skip the upper half of the byte path
                            nib_q   <= init_nibble(step_q);
                            rs_q    <= 1'b0;
                            post_q  <= init_wait;
                            start_q <= 1'b1;
                            sub_q   <= SB_LO;
                        end
                        ST_CFG, ST_ADDR_A, ST_CHAR_A, ST_ADDR_B, ST_CHAR_B: begin
                            nib_q   <= next_byte[7:4];
                            lo_q    <= next_byte[3:0];
                            rs_q    <= next_rs;
                            post_q  <= next_post;
                            start_q <= 1'b1;
                            sub_q   <= SB_HI;
                        end
                        ST_SNAP: begin
`ifdef LCD_SKIP_UNCHANGED_EN
                            if (!written_q || row_A != shadow_a_q || row_B != shadow_b_q) begin
                                shadow_a_q <= row_A;
                                shadow_b_q <= row_B;
                                written_q  <= 1'b1;
                                state_q    <= ST_ADDR_A;
                            end
`else
                            shadow_a_q <= row_A;
                            shadow_b_q <= row_B;
                            state_q    <= ST_ADDR_A;
`endif
                        end
                        ST_DONE: state_q <= ST_SNAP;
                        default: state_q <= ST_PWR_WAIT;
                    endcase
                end
                SB_HI: begin
                    if (tx_done) begin
                        wait_q <= WW'(T_GAP - 1);
                        sub_q  <= SB_GAP;
                    end
                end
                SB_GAP: begin
                    if (wait_q == '0) begin
                        nib_q   <= lo_q;
                        start_q <= 1'b1;
                        sub_q   <= SB_LO;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                SB_LO: begin
                    if (tx_done) begin
                        wait_q <= post_q;
                        sub_q  <= SB_WAIT;
                    end
                end
                SB_WAIT: begin
                    if (wait_q == '0) begin
                        sub_q <= SB_IDLE;
                        case (state_q)
                            ST_INIT_NIB: begin
                                if (step_q == 2'd3) begin
                                    state_q <= ST_CFG;
                                    step_q  <= 2'd0;
                                end else begin
                                    step_q <= step_q + 2'd1;
                                end
                            end
                            ST_CFG: begin
                                if (step_q == 2'd3) begin
                                    ready_q <= 1'b1;
                                    state_q <= ST_SNAP;
                                end else begin
                                    step_q <= step_q + 2'd1;
                                end
                            end
                            ST_ADDR_A: begin
                                idx_q   <= 4'd0;
                                state_q <= ST_CHAR_A;
                            end
                            ST_CHAR_A: begin
                                idx_q <= idx_q + 4'd1;
                                if (idx_q == 4'd15) state_q <= ST_ADDR_B;
                            end
                            ST_ADDR_B: state_q <= ST_CHAR_B;
                            ST_CHAR_B: begin
                                idx_q <= idx_q + 4'd1;
                                if (idx_q == 4'd15) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;  // high for the single DONE cycle
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                default: sub_q <= SB_IDLE;
            endcase
        end
    end

    lcd4_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH)
    ) u_tx (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start_q),
        .rs_i    (rs_q),
        .nib_i   (nib_q),
        .e_o     (LCD_E),
        .rs_o    (LCD_RS),
        .d_o     (LCD_D),
        .done_o  (tx_done)
    );

    assign LCD_RW       = 1'b0;
    assign ready        = ready_q;
    assign refresh_done = done_q;

endmodule

// File: tb/tb_lcd4_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd4_frame_writer
// Scoreboard bench: every expected E pulse ({RS,D} plus the allowed low time
// before it) is queued when stimulus is applied, and popped on each E rising
// edge. Builds with or without LCD_SKIP_UNCHANGED_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd4_frame_writer;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 6;
    localparam int T_CMD   = 4;
    localparam int T_CLEAR = 8;
    localparam int T_SETUP = 1;
    localparam int T_EHIGH = 2;
    localparam int T_GAP   = 2;
    localparam int SLACK   = 10;  // control overhead allowed on top of each wait

    typedef struct {
        logic [4:0] nib;      // {RS, D}
        int         min_gap;  // minimum E-low cycles before this pulse
        int         max_gap;  // <0: unchecked
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] row_A, row_B;
    logic         ready, refresh_done, LCD_E, LCD_RS, LCD_RW;
    logic [3:0]   LCD_D;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   pulses = 0, done_cnt = 0, low_cnt = 0, done_run = 0;
    bit   e_prev = 1'b0, expect_more = 1'b1;

    always #5 clk = ~clk;

    lcd4_frame_writer #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
        .T_CLEAR(T_CLEAR), .T_SETUP(T_SETUP), .T_EHIGH(T_EHIGH), .T_GAP(T_GAP)
    ) dut (
        .clk(clk), .rst(rst), .row_A(row_A), .row_B(row_B),
        .ready(ready), .refresh_done(refresh_done),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_D(LCD_D)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // range check expressed through chk: expected is the nearest legal value
    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        int e;
        e = (obs < lo) ? lo : (obs > hi) ? hi : obs;
        chk(tag, obs, e);
    endtask

    task automatic push(input logic rs, input logic [3:0] d, input int gmin, input int gmax);
        exp_t e;
        e.nib = {rs, d};
        e.min_gap = gmin;
        e.max_gap = gmax;
        sb.push_back(e);
    endtask

    // wait_before < 0: gap before the upper nibble is not checked
    task automatic push_byte(input logic rs, input logic [7:0] b, input int wait_before);
        push(rs, b[7:4], wait_before, (wait_before < 0) ? -1 : wait_before + SLACK);
        push(rs, b[3:0], T_GAP, T_GAP + SLACK);
    endtask

    task automatic push_init();
        push(1'b0, 4'h3, T_PWRUP, T_PWRUP + SLACK);
        push(1'b0, 4'h3, T_INIT1, T_INIT1 + SLACK);
        push(1'b0, 4'h3, T_INIT2, T_INIT2 + SLACK);
        push(1'b0, 4'h2, T_CMD,   T_CMD + SLACK);
        push_byte(1'b0, 8'h28, T_CMD);
        push_byte(1'b0, 8'h06, T_CMD);
        push_byte(1'b0, 8'h0C, T_CMD);
        push_byte(1'b0, 8'h01, T_CMD);
    endtask

    task automatic push_frame(input logic [127:0] a, input logic [127:0] b, input int wait_before);
        push_byte(1'b0, 8'h80, wait_before);
        for (int i = 0; i < 16; i++) push_byte(1'b1, a[127-8*i -: 8], T_CMD);
        push_byte(1'b0, 8'hC0, T_CMD);
        for (int i = 0; i < 16; i++) push_byte(1'b1, b[127-8*i -: 8], T_CMD);
    endtask

    // E-pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            low_cnt  = 0;
            e_prev   = 1'b0;
            pulses   = 0;
            done_run = 0;
        end else begin
            if (LCD_E && !e_prev) begin
                pulses++;
                if (sb.size() == 0) begin
                    if (expect_more) chk($sformatf("extra_pulse#%0d", pulses), 32'(LCD_E), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("nib#%0d", pulses), 32'({LCD_RS, LCD_D}), 32'(e.nib));
                    chk($sformatf("rw#%0d", pulses), 32'(LCD_RW), 32'd0);
                    if (e.max_gap >= 0)
                        chk_range($sformatf("gap#%0d", pulses), low_cnt, e.min_gap, e.max_gap);
                end
                low_cnt = 0;
            end else if (!LCD_E) begin
                low_cnt++;
            end
            e_prev = LCD_E;
            if (refresh_done) begin
                if (done_run == 0) done_cnt++;
                done_run++;
            end else if (done_run != 0) begin
                chk("done_width", done_run, 1);
                done_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int n, input string tag);
        int cyc = 0;
        while (pulses < n && cyc < 5000) begin tick(); cyc++; end
        chk(tag, pulses, n);
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        chk({tag, "_early"}, 32'(ready), 32'd0);
        while (!ready && cyc < 60) begin tick(); cyc++; end
        chk(tag, 32'(ready), 32'd1);
        chk_range({tag, "_delay"}, cyc, T_CLEAR, T_CLEAR + SLACK);
    endtask

    task automatic wait_done(input int k);
        int cyc = 0;
        chk("done_early", done_cnt, k - 1);
        while (done_cnt < k && cyc < 60) begin tick(); cyc++; end
        chk("refresh_done", done_cnt, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_E"},     32'(LCD_E), 32'd0);
        chk({tag, "_RS"},    32'(LCD_RS), 32'd0);
        chk({tag, "_RW"},    32'(LCD_RW), 32'd0);
        chk({tag, "_D"},     32'(LCD_D), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_done"},  32'(refresh_done), 32'd0);
    endtask

    initial begin
        logic [127:0] s1, s2, s3, s4;
        int base;
        s1 = "Prime #01 is 002";
        s2 = "Prime #02 is 003";
        s3 = "Prime #03 is 005";
        s4 = "Prime #04 is 007";
        row_A = s1;
        row_B = s2;

        rst = 1'b1;
        tick();
        check_reset_outputs("rst0");
        tick();
        push_init();
        push_frame(s1, s2, T_CLEAR);
        rst = 1'b0;

        wait_pulses(12, "init_stream");
        wait_ready("ready");

        // after the 5th char of row A: the rest of this frame keeps the old text
        wait_pulses(12 + 2 + 10, "char5");
        row_A = s3;
        push_frame(s3, s2, T_CMD);

        wait_pulses(80, "frame1");
        wait_done(1);

        // change row_B mid frame 2 so frame 3 differs (also in skip mode)
        wait_pulses(90, "frame2_mid");
        row_B = s4;
        push_frame(s3, s4, T_CMD);

        wait_pulses(148, "frame2");
        wait_done(2);

        // reset in the middle of CHAR_B of frame 3
        wait_pulses(148 + 2 + 32 + 2 + 6, "frame3_charb");
        sb.delete();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        push_init();
        push_frame(s3, s4, T_CLEAR);
        base = done_cnt;
        rst = 1'b0;

        wait_pulses(12, "reinit_stream");
        wait_ready("reready");
`ifndef LCD_SKIP_UNCHANGED_EN
        push_frame(s3, s4, T_CMD);
`endif
        wait_pulses(80, "reframe1");
        wait_done(base + 1);

`ifdef LCD_SKIP_UNCHANGED_EN
        // unchanged rows: no further writes
        repeat (1000) tick();
        chk("skip_pulses", pulses, 80);
        chk("skip_done", done_cnt, base + 1);
        row_B[127:120] = row_B[127:120] ^ 8'h01;
        push_frame(s3, row_B, -1);
        wait_pulses(148, "skip_newframe");
        wait_done(base + 2);
        repeat (200) tick();
        chk("skip_after", pulses, 148);
`else
        // frames continue back-to-back
        wait_pulses(148, "reframe2");
        wait_done(base + 2);
`endif
        expect_more = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
